// File: rtl/elastic_fifo_struct.sv
// DEPTH-entry elastic buffer with typed payload, valid/ready on both sides and flush on mispredict.
// Define ELASTIC_FIFO_BYPASS_EN to let an empty buffer pass data_in straight to data_out.
module elastic_fifo_struct #(
   parameter type T        = logic,
   parameter int  DEPTH    = 4,
   parameter int  AF_LEVEL = DEPTH - 1,
   localparam int CNT_W    = $clog2(DEPTH + 1),
   localparam int PTR_W    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mispredict,
   input  logic             valid_in,
   output logic             ready_in,
   input  T                 data_in,
   output logic             valid_out,
   input  logic             ready_out,
   output T                 data_out,
   output logic [CNT_W-1:0] count,
   output logic             almost_full
);

   T                 mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             flush;
   logic             push;
   logic             pop;

   // Wrap explicitly at DEPTH-1 so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign flush       = reset || mispredict;
   assign ready_in    = (count != CNT_W'(DEPTH));
   assign almost_full = (count >= CNT_W'(AF_LEVEL));

`ifdef ELASTIC_FIFO_BYPASS_EN
   logic bypass;

   // A bypassed payload taken downstream this cycle is never written.
   assign bypass    = (count == '0) && valid_in && !flush;
   assign valid_out = (count != '0) || bypass;
   assign data_out  = bypass ? data_in : mem[rd_ptr];
   assign push      = valid_in && ready_in && !(bypass && ready_out);
   assign pop       = (count != '0) && ready_out;
`else
   assign valid_out = (count != '0);
   assign data_out  = mem[rd_ptr];
   assign push      = valid_in && ready_in;
   assign pop       = valid_out && ready_out;
`endif

   always_ff @(posedge clk) begin
      if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= data_in;
            wr_ptr      <= advance(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= advance(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_elastic_fifo_struct.sv
// Directed bench for elastic_fifo_struct: DEPTH=4 and DEPTH=3 instances with a packed-struct payload.
// Honours ELASTIC_FIFO_BYPASS_EN when it is defined for the build.
module tb_elastic_fifo_struct;

   typedef struct packed {
      logic [3:0] hi;
      logic [3:0] lo;
   } pay_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic mispredict = 1'b0;

   logic       v4_in = 1'b0, r4_out = 1'b0;
   logic       r4_in, v4_out, af4;
   pay_t       d4_in = '0;
   pay_t       d4_out;
   logic [2:0] c4;

   logic       v3_in = 1'b0, r3_out = 1'b0;
   logic       r3_in, v3_out, af3;
   pay_t       d3_in = '0;
   pay_t       d3_out;
   logic [1:0] c3;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   elastic_fifo_struct #(.T(pay_t), .DEPTH(4)) u4 (
      .clk(clk), .reset(reset), .mispredict(mispredict),
      .valid_in(v4_in), .ready_in(r4_in), .data_in(d4_in),
      .valid_out(v4_out), .ready_out(r4_out), .data_out(d4_out),
      .count(c4), .almost_full(af4)
   );

   elastic_fifo_struct #(.T(pay_t), .DEPTH(3)) u3 (
      .clk(clk), .reset(reset), .mispredict(1'b0),
      .valid_in(v3_in), .ready_in(r3_in), .data_in(d3_in),
      .valid_out(v3_out), .ready_out(r3_out), .data_out(d3_out),
      .count(c3), .almost_full(af3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pushed;
      int popped;
      int ec;
      logic [7:0] exp_b;

      // reset
      tick();
      reset = 1'b0;
      check("rst_ready_in", 32'(r4_in), 1);
      check("rst_valid_out", 32'(v4_out), 0);
      check("rst_count", 32'(c4), 0);
      check("rst_almost_full", 32'(af4), 0);
      check("rst_data_out", {24'h0, d4_out}, 0);

      // fill with downstream stalled
      v4_in = 1'b1;
      r4_out = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d4_in = pay_t'(8'hA1 + 8'(i));
         tick();
         check("fill_count", 32'(c4), 32'(i + 1));
         check("fill_af", 32'(af4), (i + 1 >= 3) ? 1 : 0);
         check("fill_ready_in", 32'(r4_in), (i + 1 == 4) ? 0 : 1);
         check("fill_head", {24'h0, d4_out}, 32'hA1);
         check("fill_valid_out", 32'(v4_out), 1);
      end
      d4_in = pay_t'(8'hA5);
      tick();
      check("full_reject_count", 32'(c4), 4);

      // drain
      v4_in = 1'b0;
      r4_out = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_valid", 32'(v4_out), 1);
         check("drain_data", {24'h0, d4_out}, 32'hA1 + 32'(i));
         tick();
      end
      check("drain_empty_valid", 32'(v4_out), 0);
      check("drain_empty_count", 32'(c4), 0);
      check("drain_empty_ready", 32'(r4_in), 1);

      // streaming at count 2
      r4_out = 1'b0;
      v4_in = 1'b1;
      d4_in = pay_t'(8'hB0);
      tick();
      d4_in = pay_t'(8'hB1);
      tick();
      check("stream_pre_count", 32'(c4), 2);
      r4_out = 1'b1;
      for (int i = 0; i < 20; i++) begin
         d4_in = pay_t'(8'hC0 + 8'(i));
         exp_b = (i < 2) ? 8'hB0 + 8'(i) : 8'hC0 + 8'(i - 2);
         check("stream_data", {24'h0, d4_out}, {24'h0, exp_b});
         tick();
         check("stream_count", 32'(c4), 2);
      end
      v4_in = 1'b0;
      check("stream_tail0", {24'h0, d4_out}, 32'hD2);
      tick();
      check("stream_tail1", {24'h0, d4_out}, 32'hD3);
      tick();
      check("stream_end_count", 32'(c4), 0);

      // mispredict with push and pop in the same cycle
      r4_out = 1'b0;
      v4_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d4_in = pay_t'(8'h71 + 8'(i));
         tick();
      end
      check("mp_pre_count", 32'(c4), 3);
      d4_in = pay_t'(8'hEE);
      r4_out = 1'b1;
      mispredict = 1'b1;
      tick();
      mispredict = 1'b0;
      v4_in = 1'b0;
      r4_out = 1'b0;
      check("mp_count", 32'(c4), 0);
      check("mp_valid_out", 32'(v4_out), 0);
      check("mp_ready_in", 32'(r4_in), 1);
      check("mp_af", 32'(af4), 0);
      check("mp_data_cleared", {24'h0, d4_out}, 0);
      v4_in = 1'b1;
      d4_in = pay_t'(8'h11);
      tick();
      v4_in = 1'b0;
      check("mp_next_data", {24'h0, d4_out}, 32'h11);
      check("mp_next_count", 32'(c4), 1);

      // reset and mispredict together
      reset = 1'b1;
      mispredict = 1'b1;
      tick();
      reset = 1'b0;
      mispredict = 1'b0;
      check("both_flush_count", 32'(c4), 0);
      check("both_flush_valid", 32'(v4_out), 0);

      // bypass / one-cycle latency
      v4_in = 1'b1;
      r4_out = 1'b1;
      d4_in = pay_t'(8'h5C);
      #1;
`ifdef ELASTIC_FIFO_BYPASS_EN
      check("byp_valid_same", 32'(v4_out), 1);
      check("byp_data_same", {24'h0, d4_out}, 32'h5C);
      tick();
      v4_in = 1'b0;
      check("byp_count", 32'(c4), 0);
`else
      check("lat_valid_same", 32'(v4_out), 0);
      tick();
      v4_in = 1'b0;
      r4_out = 1'b0;
      check("lat_data_next", {24'h0, d4_out}, 32'h5C);
      check("lat_valid_next", 32'(v4_out), 1);
      check("lat_count_next", 32'(c4), 1);
      r4_out = 1'b1;
      tick();
      check("lat_drain_count", 32'(c4), 0);
`endif
      r4_out = 1'b0;

      // DEPTH=3 interleaved traffic across pointer wraps
      pushed = 0;
      popped = 0;
      ec = 0;
      for (int cyc = 0; cyc < 40 && popped < 10; cyc++) begin
         bit do_push;
         bit do_pop;
         v3_in = (pushed < 10);
         d3_in = pay_t'(8'h30 + 8'(pushed));
         r3_out = (cyc % 3) != 0;
         #1;
         do_push = v3_in && (ec < 3);
         do_pop = r3_out && (ec > 0);
`ifdef ELASTIC_FIFO_BYPASS_EN
         if (ec == 0 && v3_in && r3_out) begin
            check("d3_bypass_data", {24'h0, d3_out}, 32'h30 + 32'(popped));
            popped++;
            pushed++;
            do_push = 1'b0;
         end
`endif
         if (do_pop) begin
            check("d3_valid", 32'(v3_out), 1);
            check("d3_data", {24'h0, d3_out}, 32'h30 + 32'(popped));
            popped++;
         end
         if (do_push) pushed++;
         ec = ec + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
         tick();
         check("d3_count", 32'(c3), 32'(ec));
      end
      v3_in = 1'b0;
      r3_out = 1'b0;
      check("d3_all_popped", 32'(popped), 10);
      check("d3_end_valid", 32'(v3_out), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/elastic_fifo_struct.md
# elastic_fifo_struct

Parametrised multi-entry elastic buffer carrying a typed payload between out-of-order pipeline stages (decode→rename, rename→dispatch, issue→execute). It generalises the single-entry stage register to DEPTH entries with full valid/ready decoupling. Occupancy and almost-full status are exported for upstream throttling, and the whole buffer flushes on branch mispredict.

## Interface
- T, logic: payload type (packed struct).
- DEPTH, 4: number of entries; legal range ≥2, any integer (not restricted to powers of two).
- AF_LEVEL, DEPTH-1: almost_full threshold; legal range 1..DEPTH.
- Derived, not overridable: CNT_W = $clog2(DEPTH+1); PTR_W = $clog2(DEPTH).

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- mispredict  input  1  synchronous flush; same effect as reset.
- valid_in  input  1  upstream payload valid.
- ready_in  output  1  buffer can accept a payload this cycle.
- data_in  input  T  upstream payload.
- valid_out  output  1  data_out holds a valid payload.
- ready_out  input  1  downstream accepts this cycle.
- data_out  output  T  head payload.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- almost_full  output  1  asserted when count ≥ AF_LEVEL.

## Operation
- Storage is a circular array mem[DEPTH] with rd_ptr and wr_ptr (PTR_W bits each) and a count register (CNT_W bits).
- push = valid_in && ready_in. pop = valid_out && ready_out.
- On push: mem[wr_ptr] ← data_in, then wr_ptr advances.
- On pop: rd_ptr advances.
- Pointer wrap: after DEPTH-1 the pointer returns to 0. There is no modulo-2^PTR_W wrap when DEPTH is not a power of two.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- ready_in = (count != DEPTH). It depends only on registered state; there is no combinational path from ready_out to ready_in.
- valid_out = (count != 0). data_out = mem[rd_ptr].
- Full: ready_in = 0. A pop in the full cycle frees one slot, but ready_in does not rise until the next cycle.
- Empty: valid_out = 0. data_out shows the stale mem[rd_ptr] and must not be sampled.
- Simultaneous push and pop when 0 < count < DEPTH: both occur; count is unchanged and FIFO order is preserved.
- reset or mispredict asserted at a clock edge:
  - rd_ptr, wr_ptr and count are cleared to 0 and every mem entry is cleared to 0.
  - Any push or pop handshake presented in that cycle is discarded.
  - reset and mispredict together behave the same as either alone.
- Reset values of outputs: ready_in = 1, valid_out = 0, data_out = 0, count = 0, almost_full = 0 (requires AF_LEVEL ≥ 1).

## Timing
- Latency: a payload pushed at edge N is visible on data_out with valid_out = 1 after edge N (the cycle following the push), provided the buffer was empty.
- Throughput is one push and one pop per cycle sustained at any occupancy 0 < count < DEPTH.
- Outputs count, ready_in, valid_out and almost_full are derived from registers only.
- data_out is a mux of mem selected by rd_ptr; there is no input-to-output combinational path (except in bypass mode, below).
- Flush takes effect at the edge on which mispredict is sampled high. The buffer is empty and ready the following cycle.

## Configuration
- Macro: ELASTIC_FIFO_BYPASS_EN.
- When defined, with count == 0, valid_in = 1 and mispredict = 0:
  - valid_out = 1 and data_out = data_in combinationally.
  - If ready_out = 1, the payload is consumed with zero latency and is not written; count stays 0.
  - If ready_out = 0, the payload is written normally.
  - ready_in is unchanged (still count-based).
  - The bypass path is gated off during reset or mispredict cycles.
- When undefined: minimum latency is 1 cycle, and there is no valid_in→valid_out or data_in→data_out path.

## Test plan
- Reset then idle, DEPTH = 4: ready_in = 1, valid_out = 0, count = 0, almost_full = 0, data_out = 0.
- Fill with ready_out = 0, payloads 0xA1..0xA4:
  - count steps 1, 2, 3, 4.
  - almost_full rises when count = 3.
  - ready_in falls when count = 4.
  - A fifth valid_in is not accepted.
  - Then raise ready_out: data_out sequence is 0xA1, 0xA2, 0xA3, 0xA4, and valid_out drops after the fourth pop.
- Streaming at count = 2 with valid_in = ready_out = 1 for 20 cycles:
  - count stays at 2.
  - The output order matches the input order across multiple pointer wraps.
- DEPTH = 3 (not a power of two): 10 pushes and pops interleaved; pointers wrap 2→0 and no payload is lost or duplicated.
- Mispredict with count = 3 and push and pop both active in the same cycle: next cycle count = 0, valid_out = 0, ready_in = 1; the pushed payload never appears.
- With ELASTIC_FIFO_BYPASS_EN, empty buffer, valid_in = 1, ready_out = 1, data_in = 0x5C: data_out = 0x5C in the same cycle and count stays 0. Without the macro, 0x5C appears one cycle later.
